// File: rtl/burst_tx_pkg.sv
// Shared types for the burst word transmitter and its FIFO.
package burst_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/burst_tx_fifo.sv
// Synchronous FIFO with registered level/full; a write while full is accepted
// only if a pop frees a slot on the same edge, otherwise it is reported as dropped.
module burst_tx_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              wr_drop,
   output logic [CNT_W-1:0]  level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  level_q, level_d;
   logic              full_q, full_d;
   logic              pop_ok;
   logic              push;

   assign pop_ok  = pop && (level_q != '0);
   assign push    = wr_en && (!full_q || pop_ok);
   assign wr_drop = wr_en && full_q && !pop_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop_ok})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase
      full_d = (level_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
      end
   end

   // Storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign level   = level_q;

endmodule

// File: rtl/burst_word_tx.sv
// Burst transmitter: snapshots FIFO occupancy on tx_enable and streams that many
// words over valid/ready. Optional even parity output with BURST_TX_PARITY_EN.
module burst_word_tx
   import burst_tx_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              overflow,
   input  logic              tx_enable,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
`ifdef BURST_TX_PARITY_EN
   output logic              dout_par,
`endif
   output logic              done,
   output logic [CNT_W-1:0]  level
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              overflow_q, overflow_d;
   logic              pop;
   logic              wr_drop;
   logic [DATA_W-1:0] rd_data;
   logic [CNT_W-1:0]  fifo_level;
`ifdef BURST_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   burst_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (full),
      .wr_drop (wr_drop),
      .level   (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      dout_d      = dout_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      remaining_d = remaining_q;
      overflow_d  = overflow_q | wr_drop;
      pop         = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tx_enable && (fifo_level != '0)) begin
               remaining_d = fifo_level;
               pop         = 1'b1;
               dout_d      = rd_data;
               valid_d     = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (valid_q && dout_ready) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q > CNT_W'(1)) begin
                  pop    = 1'b1;
                  dout_d = rd_data;
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
`ifdef BURST_TX_PARITY_EN
      par_d = pop ? ^rd_data : par_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
`ifdef BURST_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
`ifdef BURST_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign level      = fifo_level;
`ifdef BURST_TX_PARITY_EN
   assign dout_par   = par_q;
`endif

endmodule

// File: tb/tb_burst_word_tx.sv
// Scoreboard bench for burst_word_tx: accepted writes are queued, each output
// handshake pops and compares the oldest expected word.
module tb_burst_word_tx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              overflow;
   logic              tx_enable;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              done;
   logic [CNT_W-1:0]  level;
`ifdef BURST_TX_PARITY_EN
   logic              dout_par;
`endif

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int unsigned done_cnt = 0;
   logic [DATA_W-1:0] exp_q [$];
   logic              prev_stall;
   logic [DATA_W-1:0] prev_dout;
   int unsigned       cyc;
   int unsigned       done_snap;

   burst_word_tx #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .overflow   (overflow),
      .tx_enable  (tx_enable),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
`ifdef BURST_TX_PARITY_EN
      .dout_par   (dout_par),
`endif
      .done       (done),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Outputs are sampled on the falling edge, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_valid", 32'(dout_valid), 32'd1);
            check_eq("hold_dout", 32'(dout), 32'(prev_dout));
         end
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
               check_eq("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
`ifdef BURST_TX_PARITY_EN
            check_eq("dout_par", 32'(dout_par), 32'(^dout));
`endif
         end
         if (done) begin
            done_cnt++;
            check_eq("done_vs_valid", 32'(dout_valid), 32'd0);
         end
         prev_stall <= dout_valid && !dout_ready;
         prev_dout  <= dout;
      end
   end

   task automatic write_word(input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget, output int unsigned cycles);
      cycles = 0;
      while (cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
         if (done) break;
      end
      if (!done) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      tx_enable  = 1'b0;
      dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(dout_valid), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 3-word burst
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      check_eq("basic_level", 32'(level), 32'd3);
      dout_ready = 1'b1;
      tx_enable  = 1'b1;
      wait_done(20, cyc);
      tx_enable = 1'b0;
      check_eq("basic_cycles", cyc, 32'd4);
      check_eq("basic_level_after", 32'(level), 32'd0);
      check_eq("basic_sb_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;
      check_eq("done_one_cycle", 32'(done), 32'd0);

      // Back-pressure: stall the first word for 3 cycles
      write_word(8'hA5);
      write_word(8'h5A);
      dout_ready = 1'b0;
      tx_enable  = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_first_valid", 32'(dout_valid), 32'd1);
      check_eq("bp_first_dout", 32'(dout), 32'hA5);
      tx_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("bp_held_dout", 32'(dout), 32'hA5);
      dout_ready = 1'b1;
      wait_done(20, cyc);
      check_eq("bp_cycles", cyc, 32'd2);
      check_eq("bp_sb_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;

      // Overflow: 9 writes into 8 slots
      for (int i = 1; i <= 9; i++) begin
         write_word(8'(i));
         if (i == 8) begin
            check_eq("ovf_full8", 32'(full), 32'd1);
            check_eq("ovf_level8", 32'(level), 32'd8);
            check_eq("ovf_flag8", 32'(overflow), 32'd0);
         end
      end
      check_eq("ovf_flag9", 32'(overflow), 32'd1);
      check_eq("ovf_level9", 32'(level), 32'd8);
      tx_enable = 1'b1;
      wait_done(30, cyc);
      tx_enable = 1'b0;
      check_eq("ovf_cycles", cyc, 32'd9);
      check_eq("ovf_sb_empty", exp_q.size(), 32'd0);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);
      check_eq("ovf_full_after", 32'(full), 32'd0);
      @(posedge clk); #1;

      // Write during a burst waits for the following burst
      write_word(8'hC1);
      write_word(8'hC2);
      done_snap = done_cnt;
      tx_enable = 1'b1;
      @(posedge clk); #1;
      write_word(8'h77);
      wait_done(20, cyc);
      check_eq("wdb_first_cycles", cyc, 32'd1);
      check_eq("wdb_level_mid", 32'(level), 32'd1);
      wait_done(20, cyc);
      tx_enable = 1'b0;
      check_eq("wdb_second_cycles", cyc, 32'd3);
      @(posedge clk); #1;
      check_eq("wdb_done_count", done_cnt - done_snap, 32'd2);
      check_eq("wdb_sb_empty", exp_q.size(), 32'd0);

      // Reset in the middle of a stalled burst
      write_word(8'h01);
      write_word(8'h02);
      write_word(8'h03);
      dout_ready = 1'b0;
      tx_enable  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("mid_valid_pre", 32'(dout_valid), 32'd1);
      done_snap = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_valid", 32'(dout_valid), 32'd0);
      check_eq("mid_level", 32'(level), 32'd0);
      check_eq("mid_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n      = 1'b1;
      dout_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("mid_no_done", done_cnt - done_snap, 32'd0);
      check_eq("mid_idle_valid", 32'(dout_valid), 32'd0);
      tx_enable = 1'b0;

      // Post-reset burst also exercises parity values 0x07 and 0x03
      write_word(8'h07);
      write_word(8'h03);
      dout_ready = 1'b0;
      tx_enable  = 1'b1;
      @(posedge clk); #1;
      tx_enable = 1'b0;
      check_eq("par_dout07", 32'(dout), 32'h07);
`ifdef BURST_TX_PARITY_EN
      check_eq("par_07", 32'(dout_par), 32'd1);
`endif
      dout_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("par_dout03", 32'(dout), 32'h03);
`ifdef BURST_TX_PARITY_EN
      check_eq("par_03", 32'(dout_par), 32'd0);
`endif
      wait_done(20, cyc);
      check_eq("par_cycles", cyc, 32'd1);
      check_eq("par_sb_empty", exp_q.size(), 32'd0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
